// File: rtl/ps2_key_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_key_sequencer
//
// Sits between a PS/2 receiver and the CORDIC front-end command logic.
// Raw scan-code bytes are folded into complete key events by resolving the
// E0 (extended) and F0 (break) prefixes. Events are buffered in a small
// first-word-fall-through FIFO. FIFO occupancy throttles the receiver
// through rx_en, so a frame is only started when it can be stored.
//
// Ports
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   rx_done_tick  in   one-cycle pulse: receiver finished a frame
//   scan_code     in   [7:0] raw byte, valid the cycle after rx_done_tick
//   rx_en         out  receiver may start a new frame
//   key_valid     out  head event presented (FIFO non-empty)
//   key_ready     in   consumer accepts the head event
//   key_code      out  [7:0] head event scan code
//   key_ext       out  head event carried an E0 prefix
//   key_break     out  head event is a release (F0 prefix)
//   fifo_count    out  [log2(DEPTH):0] current occupancy
//   overflow      out  sticky: an event was dropped on a full FIFO
//   proto_err     out  one-cycle pulse: prefix timeout or byte 00/FF
//   dbg_state     out  [1:0] decoder state (0 IDLE, 1 EXT, 2 BRK, 3 EXT_BRK)
//
// Handshake: an event transfers on every rising edge where key_valid and
// key_ready are both high. key_valid never depends on key_ready, and the
// head event stays stable on key_* until it is transferred.
// ---------------------------------------------------------------------------
module ps2_key_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rx_done_tick,
    input  logic [7:0]               scan_code,
    output logic                     rx_en,
    output logic                     key_valid,
    input  logic                     key_ready,
    output logic [7:0]               key_code,
    output logic                     key_ext,
    output logic                     key_break,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     proto_err,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   CNT_FULL  = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_HIGH  = CNT_FULL - CNT_ONE;
    localparam logic [23:0]   TMO_LIMIT = TIMEOUT[23:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Byte strobe: scan_code settles one cycle after rx_done_tick, so the
    // decoder works on the delayed strobe.
    // ------------------------------------------------------------------
    logic r_tick_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_d <= 1'b0;
        end else begin
            r_tick_d <= rx_done_tick;
        end
    end

    // ------------------------------------------------------------------
    // Decoder FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_next_state;
    logic [23:0] r_tmo_cnt;
    logic [23:0] w_tmo_cnt_next;
    logic        w_push;
    logic [9:0]  w_push_data;
    logic        w_byte_err;
    logic        w_timeout;
    logic        w_bad_byte;
    logic        w_status_byte;
    logic        r_proto_err;

    assign w_bad_byte    = (scan_code == 8'h00) || (scan_code == 8'hFF);
    assign w_status_byte = (scan_code == 8'hFA) || (scan_code == 8'hAA) ||
                           (scan_code == 8'hEE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_tmo_cnt   <= 24'd0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_tmo_cnt   <= w_tmo_cnt_next;
            r_proto_err <= w_byte_err | w_timeout;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_push_data  = 10'd0;
        w_byte_err   = 1'b0;
        w_timeout    = 1'b0;

        if (r_tick_d) begin
            // A byte arriving in the same cycle as the limit wins: it is a
            // legitimate continuation of the pending prefix.
            unique case (r_state)
                S_IDLE: begin
                    if (w_bad_byte) begin
                        w_byte_err = 1'b1;
                    end else if (scan_code == 8'hE0) begin
                        w_next_state = S_EXT;
                    end else if (scan_code == 8'hF0) begin
                        w_next_state = S_BRK;
                    end else if (!w_status_byte) begin
                        w_push      = 1'b1;
                        w_push_data = {2'b00, scan_code};
                    end
                end
                S_EXT: begin
                    if (w_bad_byte) begin
                        w_byte_err   = 1'b1;
                        w_next_state = S_IDLE;
                    end else if (scan_code == 8'hF0) begin
                        w_next_state = S_EXT_BRK;
                    end else if (scan_code == 8'hE0) begin
                        w_next_state = S_EXT;
                    end else begin
                        w_push       = 1'b1;
                        w_push_data  = {2'b10, scan_code};
                        w_next_state = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_next_state = S_IDLE;
                    if (w_bad_byte) begin
                        w_byte_err = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_push_data = {2'b01, scan_code};
                    end
                end
                S_EXT_BRK: begin
                    w_next_state = S_IDLE;
                    if (w_bad_byte) begin
                        w_byte_err = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_push_data = {2'b11, scan_code};
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end else if ((r_state != S_IDLE) && (r_tmo_cnt == TMO_LIMIT)) begin
            // Prefix left dangling: abandon it without producing an event.
            w_timeout    = 1'b1;
            w_next_state = S_IDLE;
        end
    end

    // Counter restarts on every byte and whenever the decoder lands in IDLE,
    // so it only measures silence after a prefix.
    always_comb begin
        w_tmo_cnt_next = r_tmo_cnt;
        if (r_tick_d || (w_next_state == S_IDLE)) begin
            w_tmo_cnt_next = 24'd0;
        end else if (r_state != S_IDLE) begin
            w_tmo_cnt_next = r_tmo_cnt + 24'd1;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO, entries {ext, brk, code}
    // ------------------------------------------------------------------
    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_wr_en;
    logic [9:0]    w_head;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && key_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_wr_en) begin
                r_count <= r_count - CNT_ONE;
            end
            if (w_push && !w_wr_en) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The head is masked while empty so stale storage never leaks
    // onto key_* (and reset values are zero without resetting the array).
    // ------------------------------------------------------------------
    assign key_valid  = !w_empty;
    assign key_code   = w_empty ? 8'h00 : w_head[7:0];
    assign key_break  = w_empty ? 1'b0  : w_head[8];
    assign key_ext    = w_empty ? 1'b0  : w_head[9];
    assign fifo_count = r_count;
    // One slot stays free for a frame already on the wire when rx_en drops.
    assign rx_en      = (r_count < CNT_HIGH);
    assign overflow   = r_overflow;
    assign proto_err  = r_proto_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
module tb_ps2_key_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 40;
    localparam logic [18:0] RESET_VEC = {1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0};

    logic       clk;
    logic       reset_n;
    logic       rx_done_tick;
    logic [7:0] scan_code;
    logic       rx_en;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       proto_err;
    logic [1:0] dbg_state;

    logic [9:0] exp_q[$];
    int         n_checks;
    int         n_pass;

    ps2_key_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_done_tick (rx_done_tick),
        .scan_code    (scan_code),
        .rx_en        (rx_en),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_break    (key_break),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .proto_err    (proto_err),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard: every accepted event is compared with the oldest expected.
    always @(negedge clk) begin
        if (reset_n && key_valid && key_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got %h required no event", {key_ext, key_break, key_code});
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({key_ext, key_break, key_code} !== e)
                    $display("FAIL sb_event: got %h required %h", {key_ext, key_break, key_code}, e);
                else
                    n_pass++;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_done_tick = 1'b1;
        scan_code    = b;
        tick();
        rx_done_tick = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scenarios
    task automatic test_reset();
        reset_n = 1'b0;
        wait_neg(2);
        n_checks++;
        if ({key_valid, key_code, key_ext, key_break, fifo_count, overflow, proto_err, rx_en, dbg_state} !== RESET_VEC)
            $display("FAIL reset_outputs: got %h required %h",
                     {key_valid, key_code, key_ext, key_break, fifo_count, overflow, proto_err, rx_en, dbg_state}, RESET_VEC);
        else n_pass++;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        key_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        send_byte(8'h1C);
        @(negedge clk);
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL single_t1_valid: got %b required 0", key_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({key_valid, key_code} !== {1'b1, 8'h1C}) $display("FAIL single_t2_head: got %h required 11c", {key_valid, key_code});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (key_valid !== 1'b0) $display("FAIL single_drop: got %b required 0", key_valid);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL single_sb_empty: got %0d required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_ext_break();
        key_ready = 1'b0;
        send_byte(8'hE0);
        wait_neg(2);
        n_checks++;
        if ({key_valid, fifo_count} !== 4'd0) $display("FAIL eb_e0_no_event: got %h required 0", {key_valid, fifo_count});
        else n_pass++;
        send_byte(8'hF0);
        wait_neg(2);
        n_checks++;
        if ({key_valid, fifo_count} !== 4'd0) $display("FAIL eb_f0_no_event: got %h required 0", {key_valid, fifo_count});
        else n_pass++;
        exp_q.push_back({2'b11, 8'h75});
        send_byte(8'h75);
        @(negedge clk);
        n_checks++;
        if (fifo_count !== 3'd0) $display("FAIL eb_count_t1: got %0d required 0", fifo_count);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (fifo_count !== 3'd1) $display("FAIL eb_count_t2: got %0d required 1", fifo_count);
        else n_pass++;
        n_checks++;
        if ({key_ext, key_break, key_code} !== {2'b11, 8'h75})
            $display("FAIL eb_head: got %h required 375", {key_ext, key_break, key_code});
        else n_pass++;
        tick();
        key_ready = 1'b1;
        wait_neg(2);
        n_checks++;
        if (fifo_count !== 3'd0) $display("FAIL eb_drained: got %0d required 0", fifo_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            int         w;
            logic [1:0] kind;
            logic [7:0] code;
            kind      = 2'($urandom_range(0, 3));
            code      = 8'($urandom_range(1, 127));
            key_ready = 1'($urandom_range(0, 1));
            w = 0;
            while (!rx_en && w < 50) begin
                key_ready = 1'b1;
                tick();
                w++;
            end
            n_checks++;
            if (rx_en !== 1'b1) $display("FAIL b2b_rx_en_wait: got %b required 1", rx_en);
            else n_pass++;
            if (kind[0]) send_byte(8'hE0);
            if (kind[1]) send_byte(8'hF0);
            exp_q.push_back({kind[0], kind[1], code});
            send_byte(code);
        end
        key_ready = 1'b1;
        for (int w = 0; w < 60 && (exp_q.size() != 0 || key_valid); w++) tick();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d left required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL b2b_no_overflow: got %b required 0", overflow);
        else n_pass++;
    endtask

    task automatic test_drop();
        logic [7:0] bytes [3];
        bytes[0] = 8'hFA;
        bytes[1] = 8'hAA;
        bytes[2] = 8'h00;
        key_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i]);
            @(negedge clk);
            n_checks++;
            if (proto_err !== 1'b0) $display("FAIL drop_err_t1 %h: got %b required 0", bytes[i], proto_err);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (proto_err !== (bytes[i] == 8'h00))
                $display("FAIL drop_err_t2 %h: got %b required %b", bytes[i], proto_err, bytes[i] == 8'h00);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (proto_err !== 1'b0) $display("FAIL drop_err_t3 %h: got %b required 0", bytes[i], proto_err);
            else n_pass++;
        end
        n_checks++;
        if ({fifo_count, dbg_state} !== 5'd0) $display("FAIL drop_no_event: got %h required 0", {fifo_count, dbg_state});
        else n_pass++;
    endtask

    task automatic test_timeout();
        int pulses;
        int first;
        pulses    = 0;
        first     = -1;
        key_ready = 1'b1;
        send_byte(8'hF0);
        for (int n = 1; n <= TMO + 10; n++) begin
            @(negedge clk);
            if (proto_err) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
        n_checks++;
        if (pulses != 1) $display("FAIL tmo_pulses: got %0d required 1", pulses);
        else n_pass++;
        n_checks++;
        if (first != TMO + 3) $display("FAIL tmo_pulse_cycle: got %0d required %0d", first, TMO + 3);
        else n_pass++;
        n_checks++;
        if ({fifo_count, dbg_state} !== 5'd0) $display("FAIL tmo_idle_no_event: got %h required 0", {fifo_count, dbg_state});
        else n_pass++;
        exp_q.push_back({2'b00, 8'h1C});
        send_byte(8'h1C);
        wait_neg(4);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL tmo_next_event: got %0d left required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] codes [3];
        codes[0] = 8'h1C;
        codes[1] = 8'h32;
        codes[2] = 8'h21;
        key_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({2'b00, codes[i]});
            send_byte(codes[i]);
            wait_neg(2);
            n_checks++;
            if ({fifo_count, rx_en} !== {3'(i + 1), i < 2})
                $display("FAIL bp_fill_%0d: got count %0d rx_en %b required count %0d rx_en %b",
                         i, fifo_count, rx_en, i + 1, i < 2);
            else n_pass++;
        end
        exp_q.push_back({2'b00, 8'h23});
        send_byte(8'h23);
        wait_neg(2);
        n_checks++;
        if ({fifo_count, overflow} !== {3'd4, 1'b0}) $display("FAIL bp_fourth: got count %0d ovf %b required 4 0", fifo_count, overflow);
        else n_pass++;
        send_byte(8'h24);
        wait_neg(2);
        n_checks++;
        if ({overflow, fifo_count, key_code} !== {1'b1, 3'd4, 8'h1C})
            $display("FAIL bp_overflow: got ovf %b count %0d head %h required 1 4 1c", overflow, fifo_count, key_code);
        else n_pass++;
        // Push and pop in the same cycle on a full FIFO.
        exp_q.push_back({2'b00, 8'h2B});
        tick();
        rx_done_tick = 1'b1;
        scan_code    = 8'h2B;
        tick();
        rx_done_tick = 1'b0;
        key_ready    = 1'b1;
        tick();
        key_ready    = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({fifo_count, key_code} !== {3'd4, 8'h32})
            $display("FAIL bp_full_push_pop: got count %0d head %h required 4 32", fifo_count, key_code);
        else n_pass++;
        key_ready = 1'b1;
        wait_neg(8);
        n_checks++;
        if ({fifo_count, overflow, rx_en} !== {3'd0, 1'b1, 1'b1})
            $display("FAIL bp_drained: got count %0d ovf %b rx_en %b required 0 1 1", fifo_count, overflow, rx_en);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL bp_sb_empty: got %0d left required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        key_ready = 1'b0;
        send_byte(8'h1C);
        wait_neg(2);
        send_byte(8'hE0);
        wait_neg(1);
        tick();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({key_valid, key_code, key_ext, key_break, fifo_count, overflow, proto_err, rx_en, dbg_state} !== RESET_VEC)
                $display("FAIL midrst_outputs_%0d: got %h required %h", i,
                         {key_valid, key_code, key_ext, key_break, fifo_count, overflow, proto_err, rx_en, dbg_state}, RESET_VEC);
            else n_pass++;
        end
        tick();
        reset_n   = 1'b1;
        key_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        send_byte(8'h1C);
        wait_neg(4);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL midrst_event: got %0d left required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset_n      = 1'b0;
        rx_done_tick = 1'b0;
        scan_code    = 8'h00;
        key_ready    = 1'b0;
        test_reset();
        test_single();
        test_ext_break();
        test_back_to_back();
        test_drop();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Controller between the PS/2 receiver and the CORDIC front-end command logic. It gates the receiver's `rx_en`, turns raw scan-code bytes into complete key events by resolving the E0 (extended) and F0 (break) prefixes, and buffers events in a small FIFO with a valid/ready handshake. Backpressure from the FIFO throttles the receiver, so no frame is started unless it can be stored. The receiver instance feeding this block exports raw scan codes (`b_reg[8:1]`), not ASCII.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 4.
- `TIMEOUT`, 1000000: idle-cycle limit after a prefix byte; < 2^24.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_done_tick`  in  1  one-cycle pulse from the receiver; frame complete.
- `scan_code`  in  8  raw scan byte from the receiver; valid the cycle after `rx_done_tick`.
- `rx_en`  out  1  enables the receiver to start a new frame.
- `key_valid`  out  1  FIFO non-empty; head event presented.
- `key_ready`  in  1  consumer accepts the head event.
- `key_code`  out  8  head event scan code.
- `key_ext`  out  1  head event had an E0 prefix.
- `key_break`  out  1  head event is a release (F0 prefix).
- `fifo_count`  out  log2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.
- `proto_err`  out  1  one-cycle pulse on a prefix timeout or on byte 0x00/0xFF.

## Operation
- Byte strobe: `rx_done_tick` is registered once. `scan_code` is captured and decoded on the delayed strobe.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 → EXT; F0 → BRK; FA/AA/EE (ACK, BAT-OK, echo) dropped; 00/FF → `proto_err`, stay IDLE; any other byte → push {code, ext=0, brk=0}.
  - EXT: F0 → EXT_BRK; E0 → stay EXT; 00/FF → `proto_err`, IDLE; other byte → push {code, 1, 0}, IDLE.
  - BRK: 00/FF → `proto_err`, IDLE; other byte → push {code, 0, 1}, IDLE.
  - EXT_BRK: 00/FF → `proto_err`, IDLE; other byte → push {code, 1, 1}, IDLE.
- Timeout: a 24-bit counter clears on every strobe and on entry to IDLE, and increments in non-IDLE states. When it reaches `TIMEOUT`: `proto_err` pulses, the FSM returns to IDLE, and nothing is pushed.
- FIFO: 10-bit entries {ext, brk, code}, first-word-fall-through. `key_*` always show the head entry. Pop on `key_valid & key_ready`.
- `rx_en` = (`fifo_count` < DEPTH−1). This reserves one slot for a frame already in flight when `rx_en` falls.
- Push while full with no pop in the same cycle: event dropped, `overflow` set. `overflow` is cleared only by reset.
- Push and pop in the same cycle: both happen, even when full; count unchanged.

## Timing
- Reset values (async, while `reset_n`=0): FSM IDLE, FIFO empty, `fifo_count`=0, `key_valid`=0, `key_code`=0, `key_ext`=0, `key_break`=0, `overflow`=0, `proto_err`=0, timeout counter 0, `rx_en`=1 (combinational from count).
- Latency: `rx_done_tick` high in cycle T → byte decoded and pushed at the end of T+1 → `key_valid` high in T+2, if the FIFO was empty.
- `fifo_count` and `rx_en` update in the cycle after a push or pop.
- `proto_err` is high for exactly one cycle: T+2 for a byte error, or the cycle after the counter reaches `TIMEOUT`.
- Reset asserted mid-sequence discards any pending prefix and all buffered events.

## Test plan
- Bytes 1C → exactly one event {1C, ext 0, brk 0}; `key_valid` high at T+2; drops after one cycle of `key_ready`.
- Bytes E0, F0, 75 → one event {75, 1, 1}; no event for the prefix bytes; `fifo_count` goes 0→1.
- `key_ready`=0, send 1C, 32, 21 → `rx_en` low after the third push (count 3). Fourth byte 23 still accepted (count 4). Force a fifth byte 24 → `overflow`=1, count stays 4, head still 1C.
- F0, then no bytes for `TIMEOUT` cycles → single `proto_err` pulse, FSM in IDLE. Next byte 1C → make event {1C, 0, 0}.
- Bytes FA, AA, 00 in IDLE → no events; one `proto_err` pulse, on the 00 only.
- E0 sent, then `reset_n` low for 3 cycles, then 1C → event {1C, 0, 0}; all outputs at reset values during reset.
